// File: rtl/pushbutton_input_port_pkg.sv
// ----------------------------------------------------------------------------
// pushbutton_input_port_pkg
// Shared constants and types for the pushbutton input port.
//   UP_DATA_W      - default data-bus / button count of the 4-bit core
//   UP_DEB_CYCLES  - default number of stable cycles before a level is accepted
//   deb_state_t    - per-bit debounce status (synchronised input agrees with
//                    the accepted level, or is in the middle of a change)
// Build option: STICKY_CAPTURE_EN (see pushbutton_input_port.sv).
// ----------------------------------------------------------------------------
package pushbutton_input_port_pkg;

    localparam int UP_DATA_W     = 4;
    localparam int UP_DEB_CYCLES = 16;

    typedef enum logic {
        DEB_STABLE   = 1'b0,
        DEB_CHANGING = 1'b1
    } deb_state_t;

    // Smallest counter width able to hold DEB_CYCLES-1 without wrapping
    // while still satisfying 2**w > cycles.
    function automatic int debCntWidth(input int cycles);
        int w;
        w = 1;
        while ((2 ** w) <= cycles) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pushbutton_input_port_if.sv
// ----------------------------------------------------------------------------
// pushbutton_input_port_if
// Read-side bus between the core and the pushbutton input port.
//   rd_en     core -> port   read strobe, one clk per read
//   data_out  port -> core   nibble for the core's bus buffer
//   pending   port -> core   at least one captured press is waiting
// Modports:
//   master - the core side (drives rd_en)
//   slave  - the port side (drives data_out, pending)
// Build option: STICKY_CAPTURE_EN changes the meaning of data_out/pending in
// the port, not the shape of this interface.
// ----------------------------------------------------------------------------
interface pushbutton_input_port_if #(
    parameter int WIDTH = 4
);
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             pending;

    modport master (
        output rd_en,
        input  data_out,
        input  pending
    );

    modport slave (
        input  rd_en,
        output data_out,
        output pending
    );
endinterface

// File: rtl/pushbutton_input_port_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// One pushbutton bit: 2-FF synchroniser, stability counter, accepted level
// and a one-cycle rise flag.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high
//   i_raw    in   raw asynchronous button level (1 = pressed)
//   o_level  out  debounced level (registered)
//   o_rise   out  high during the cycle whose edge takes o_level from 0 to 1
// A new level is accepted on the edge where the counter sits at DEB_CYCLES-1
// and the synchronised input still disagrees with the current level, i.e.
// after DEB_CYCLES consecutive disagreeing samples.
// ----------------------------------------------------------------------------
module btn_debounce
    import pushbutton_input_port_pkg::*;
#(
    parameter int DEB_CYCLES = UP_DEB_CYCLES,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    deb_state_t       w_state;
    logic             w_accept;

    // Two-stage synchroniser; r_sync is the only copy the rest of the logic sees.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    assign w_state  = (r_sync == r_level) ? DEB_STABLE : DEB_CHANGING;
    assign w_accept = (w_state == DEB_CHANGING) &&
                      (r_cnt == CNT_W'(DEB_CYCLES - 1));

    // Any agreeing sample throws away the partial count, so a glitch shorter
    // than DEB_CYCLES never reaches the level and the counter never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            case (w_state)
                DEB_STABLE: begin
                    r_cnt <= '0;
                end
                DEB_CHANGING: begin
                    if (w_accept) begin
                        r_level <= r_sync;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    // level_next & ~level, only non-zero on the accepting edge of a press.
    assign o_rise  = w_accept & r_sync & ~r_level;

endmodule

// File: rtl/pushbutton_input_port.sv
// ----------------------------------------------------------------------------
// pushbutton_input_port
// Input stage for the 4-bit core's IN path: synchronises and debounces the
// raw pushbuttons and presents a clean nibble to the core's bus buffer.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   i_btn_raw    in   raw asynchronous pushbutton levels (1 = pressed)
//   o_btn_level  out  debounced level of each button
//   bus          slave modport of pushbutton_input_port_if
//                  rd_en (in), data_out (out), pending (out)
// Build option STICKY_CAPTURE_EN:
//   defined   - presses are latched in a capture register until the core
//               reads them; data_out = capture register, pending = |capture,
//               a read clears every bit except ones rising on that same edge.
//   undefined - data_out = debounced level, pending = 0, rd_en unused.
// ----------------------------------------------------------------------------
module pushbutton_input_port
    import pushbutton_input_port_pkg::*;
#(
    parameter int WIDTH      = UP_DATA_W,
    parameter int DEB_CYCLES = UP_DEB_CYCLES,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_btn_raw,
    output logic [WIDTH-1:0] o_btn_level,
    pushbutton_input_port_if.slave bus
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;

    // Bits are fully independent, one debouncer per button.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .i_raw   (i_btn_raw[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign o_btn_level = w_level;

`ifdef STICKY_CAPTURE_EN
    logic [WIDTH-1:0] r_cap;

    // Read-clear loads the current rises rather than zero, so a press that
    // completes on the read edge is kept for the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap <= '0;
        end else if (bus.rd_en) begin
            r_cap <= w_rise;
        end else begin
            r_cap <= r_cap | w_rise;
        end
    end

    assign bus.data_out = r_cap;
    assign bus.pending  = |r_cap;
`else
    logic w_unused;

    assign w_unused     = bus.rd_en ^ (|w_rise);
    assign bus.data_out = w_level;
    assign bus.pending  = 1'b0;
`endif

endmodule

// File: tb/tb_pushbutton_input_port.sv
// ----------------------------------------------------------------------------
// tb_pushbutton_input_port
// Directed bench for pushbutton_input_port with DEB_CYCLES=4, so a clean
// edge takes 6 clocks to reach the debounced level. Build with or without
// STICKY_CAPTURE_EN; expectations follow the same macro.
// ----------------------------------------------------------------------------
module tb_pushbutton_input_port;

    localparam int WIDTH      = 4;
    localparam int DEB_CYCLES = 4;
    localparam int CNT_W      = 3;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] btnRaw;
    logic [WIDTH-1:0] btnLevel;

    int totalChecks;
    int badChecks;

    pushbutton_input_port_if #(.WIDTH(WIDTH)) busIf ();

    pushbutton_input_port #(
        .WIDTH      (WIDTH),
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn_raw   (btnRaw),
        .o_btn_level (btnLevel),
        .bus         (busIf.slave)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the buttons and read strobe, then run for the given number of clocks.
    task automatic applyStimulus(input logic [WIDTH-1:0] btn, input logic rd, input int cycles);
        btnRaw      = btn;
        busIf.rd_en = rd;
        tick(cycles);
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        reset       = 1'b1;
        btnRaw      = 4'hF;
        busIf.rd_en = 1'b0;

        // Reset with all buttons pressed
        tick(3);
        checkOutput("rst_level", 8'(btnLevel), 8'h0);
        checkOutput("rst_data", 8'(busIf.data_out), 8'h0);
        checkOutput("rst_pend", 8'(busIf.pending), 8'h0);

        reset = 1'b0;
        applyStimulus(4'hF, 1'b0, 5);
        checkOutput("lat_5clk", 8'(btnLevel), 8'h0);
        tick(1);
        checkOutput("lat_6clk", 8'(btnLevel), 8'hF);
        checkOutput("lat_data", 8'(busIf.data_out), 8'hF);
`ifdef STICKY_CAPTURE_EN
        checkOutput("lat_pend", 8'(busIf.pending), 8'h1);
        applyStimulus(4'hF, 1'b1, 1);
        checkOutput("rd_clear", 8'(busIf.data_out), 8'h0);
`else
        checkOutput("lat_pend", 8'(busIf.pending), 8'h0);
        applyStimulus(4'hF, 1'b1, 1);
        checkOutput("rd_ignored", 8'(busIf.data_out), 8'hF);
`endif
        checkOutput("rd_pend", 8'(busIf.pending), 8'h0);
        applyStimulus(4'h0, 1'b0, 8);
        checkOutput("release_all", 8'(btnLevel), 8'h0);

        // Two back-to-back 3-clock glitches must both be rejected
        applyStimulus(4'h1, 1'b0, 3);
        applyStimulus(4'h0, 1'b0, 8);
        checkOutput("glitch3_a", 8'(btnLevel), 8'h0);
        applyStimulus(4'h1, 1'b0, 3);
        applyStimulus(4'h0, 1'b0, 8);
        checkOutput("glitch3_b", 8'(btnLevel), 8'h0);
        checkOutput("glitch3_data", 8'(busIf.data_out), 8'h0);

        // A 4-clock pulse is just long enough
        applyStimulus(4'h1, 1'b0, 4);
        applyStimulus(4'h0, 1'b0, 2);
        checkOutput("pulse4_level", 8'(btnLevel), 8'h1);
        checkOutput("pulse4_data", 8'(busIf.data_out), 8'h1);
        applyStimulus(4'h0, 1'b0, 4);
        checkOutput("pulse4_fall", 8'(btnLevel), 8'h0);
        applyStimulus(4'h0, 1'b1, 1);
        busIf.rd_en = 1'b0;
        checkOutput("pulse4_rd", 8'(busIf.data_out), 8'h0);

`ifndef STICKY_CAPTURE_EN
        // Level mode: data_out follows btn_level, rd_en has no effect
        applyStimulus(4'h5, 1'b0, 3);
        applyStimulus(4'h5, 1'b1, 1);
        applyStimulus(4'h5, 1'b0, 4);
        checkOutput("lvl_press", 8'(busIf.data_out), 8'h5);
        applyStimulus(4'h0, 1'b1, 5);
        checkOutput("lvl_rel5", 8'(busIf.data_out), 8'h5);
        applyStimulus(4'h0, 1'b1, 1);
        checkOutput("lvl_rel6", 8'(busIf.data_out), 8'h0);
        applyStimulus(4'h0, 1'b0, 1);
`else
        // Sticky: press and release before any read is still seen
        applyStimulus(4'h4, 1'b0, 8);
        applyStimulus(4'h0, 1'b0, 8);
        checkOutput("stk_level", 8'(btnLevel), 8'h0);
        checkOutput("stk_data", 8'(busIf.data_out), 8'h4);
        checkOutput("stk_pend", 8'(busIf.pending), 8'h1);
        applyStimulus(4'h0, 1'b1, 1);
        checkOutput("stk_rd_data", 8'(busIf.data_out), 8'h0);
        checkOutput("stk_rd_pend", 8'(busIf.pending), 8'h0);

        // Set wins over read-clear on the same edge
        applyStimulus(4'h8, 1'b0, 8);
        applyStimulus(4'h0, 1'b0, 8);
        checkOutput("sw_cap8", 8'(busIf.data_out), 8'h8);
        applyStimulus(4'h2, 1'b0, 5);
        applyStimulus(4'h2, 1'b1, 1);
        checkOutput("sw_data", 8'(busIf.data_out), 8'h2);
        checkOutput("sw_level", 8'(btnLevel), 8'h2);
        checkOutput("sw_pend", 8'(busIf.pending), 8'h1);
        applyStimulus(4'h0, 1'b0, 8);
        applyStimulus(4'h0, 1'b1, 1);
        busIf.rd_en = 1'b0;
        checkOutput("sw_final", 8'(busIf.data_out), 8'h0);
`endif

        // Reset mid-debounce discards the partial count
        applyStimulus(4'h8, 1'b0, 3);
        reset = 1'b1;
        applyStimulus(4'h8, 1'b0, 2);
        checkOutput("mid_rst_level", 8'(btnLevel), 8'h0);
        checkOutput("mid_rst_data", 8'(busIf.data_out), 8'h0);
        reset = 1'b0;
        applyStimulus(4'h8, 1'b0, 5);
        checkOutput("mid_rst_5clk", 8'(btnLevel), 8'h0);
        tick(1);
        checkOutput("mid_rst_6clk", 8'(btnLevel), 8'h8);
        checkOutput("mid_rst_data2", 8'(busIf.data_out), 8'h8);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
